// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-of-day chain: mode encodings,
// default moduli and field widths.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    localparam int SEC_MOD_DEF  = 60;
    localparam int MIN_MOD_DEF  = 60;
    localparam int HOUR_MOD_DEF = 24;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // Next state in the RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN ring.
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_RUN:      nxt = MODE_SET_HOUR;
            MODE_SET_HOUR: nxt = MODE_SET_MIN;
            MODE_SET_MIN:  nxt = MODE_SET_SEC;
            MODE_SET_SEC:  nxt = MODE_RUN;
            default:       nxt = MODE_RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/time_set_ctrl_mod_counter.sv
// Modulo up counter. wrap flags the increment that takes q from its
// top value back to 0 so the caller can chain the next field in the same cycle.
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);

    logic [W-1:0] q_r;
    logic         at_max_s;

    assign at_max_s = (q_r == W'(MOD - 1));
    assign wrap     = at_max_s & inc;
    assign q        = q_r;

    // Count register: clear on reset, step or wrap on inc, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r <= {W{1'b0}};
        end else if (inc) begin
            if (at_max_s) begin
                q_r <= {W{1'b0}};
            end else begin
                q_r <= q_r + W'(1);
            end
        end else begin
            q_r <= q_r;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-of-day controller: owns the sec/min/hour counters, runs the
// button-driven set-mode FSM, and emits day_carry and tick_clr pulses.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int SEC_MOD  = SEC_MOD_DEF,
    parameter int MIN_MOD  = MIN_MOD_DEF,
    parameter int HOUR_MOD = HOUR_MOD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [1:0] mode,
    output logic       day_carry,
    output logic       tick_clr
);

    mode_e state_r;
    logic  btn_mode_q_r;
    logic  btn_inc_q_r;
    logic  day_carry_r;
    logic  tick_clr_r;

    logic  mode_edge_s;
    logic  inc_edge_s;
    logic  set_inc_s;
    logic  run_s;

    logic  sec_inc_s;
    logic  min_inc_s;
    logic  hour_inc_s;
    logic  sec_wrap_s;
    logic  min_wrap_s;
    logic  hour_wrap_s;

    logic [SEC_W-1:0]  sec_s;
    logic [MIN_W-1:0]  min_s;
    logic [HOUR_W-1:0] hour_s;

    // Rising edges; the _q registers power up at 1 so a held button is not an edge.
    assign mode_edge_s = btn_mode & ~btn_mode_q_r;
    assign inc_edge_s  = btn_inc  & ~btn_inc_q_r;
    // A mode press in the same cycle wins over an increment.
    assign set_inc_s   = inc_edge_s & ~mode_edge_s;
    assign run_s       = (state_r == MODE_RUN);

    // In RUN the fields chain through wraps; in SET only the selected field steps.
    assign sec_inc_s  = run_s ? tick       : ((state_r == MODE_SET_SEC)  & set_inc_s);
    assign min_inc_s  = run_s ? sec_wrap_s : ((state_r == MODE_SET_MIN)  & set_inc_s);
    assign hour_inc_s = run_s ? min_wrap_s : ((state_r == MODE_SET_HOUR) & set_inc_s);

    mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (sec_inc_s),
        .q    (sec_s),
        .wrap (sec_wrap_s)
    );

    mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (min_inc_s),
        .q    (min_s),
        .wrap (min_wrap_s)
    );

    mod_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_hour (
        .clk  (clk),
        .rst  (rst),
        .inc  (hour_inc_s),
        .q    (hour_s),
        .wrap (hour_wrap_s)
    );

    // Mode FSM with button history and the registered carry/restart pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= MODE_RUN;
            btn_mode_q_r <= 1'b1;
            btn_inc_q_r  <= 1'b1;
            day_carry_r  <= 1'b0;
            tick_clr_r   <= 1'b0;
        end else begin
            btn_mode_q_r <= btn_mode;
            btn_inc_q_r  <= btn_inc;
            day_carry_r  <= run_s & hour_wrap_s;
            tick_clr_r   <= (state_r == MODE_SET_SEC) & mode_edge_s;
            if (mode_edge_s) begin
                state_r <= next_mode(state_r);
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign sec       = sec_s;
    assign min       = min_s;
    assign hour      = hour_s;
    assign mode      = state_r;
    assign day_carry = day_carry_r;
    assign tick_clr  = tick_clr_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed stimulus, a seconds-of-day reference
// model checked every cycle, plus literal spot checks at key points.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       day_carry;
    logic       tick_clr;

    int total = 0;
    int bad   = 0;

    time_set_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .mode      (mode),
        .day_carry (day_carry),
        .tick_clr  (tick_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: time kept as seconds of the day.
    int m_tod  = 0;
    int m_mode = 0;
    bit m_dc   = 1'b0;
    bit m_tc   = 1'b0;
    bit m_mq   = 1'b1;
    bit m_iq   = 1'b1;
    bit m_valid = 1'b0;

    always @(posedge clk) begin : model
        bit me, ie;
        int t, h, mi, s, md;
        if (!rst) begin
            m_tod <= 0; m_mode <= 0; m_dc <= 1'b0; m_tc <= 1'b0;
            m_mq <= 1'b1; m_iq <= 1'b1; m_valid <= 1'b1;
        end else begin
            me = btn_mode && !m_mq;
            ie = btn_inc && !m_iq;
            t  = m_tod; md = m_mode;
            h  = t / 3600; mi = (t / 60) % 60; s = t % 60;
            m_dc <= 1'b0; m_tc <= 1'b0;
            if (md == 0) begin
                if (tick) begin
                    if (t == 86399) m_dc <= 1'b1;
                    t = (t + 1) % 86400;
                end
                if (me) md = 1;
            end else if (me) begin
                if (md == 3) m_tc <= 1'b1;
                md = (md + 1) % 4;
            end else if (ie) begin
                if (md == 1)      h  = (h + 1) % 24;
                else if (md == 2) mi = (mi + 1) % 60;
                else              s  = (s + 1) % 60;
                t = h * 3600 + mi * 60 + s;
            end
            m_tod <= t; m_mode <= md; m_mq <= btn_mode; m_iq <= btn_inc;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_sec",  32'(sec),       32'(m_tod % 60));
            chk("m_min",  32'(min),       32'((m_tod / 60) % 60));
            chk("m_hour", 32'(hour),      32'(m_tod / 3600));
            chk("m_mode", 32'(mode),      32'(m_mode));
            chk("m_dc",   32'(day_carry), 32'(m_dc));
            chk("m_tclr", 32'(tick_clr),  32'(m_tc));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; cyc(1);
        btn_mode = 1'b0; cyc(1);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1; cyc(1);
            btn_inc = 1'b0; cyc(1);
        end
    endtask

    initial begin
        // Reset and 60 ticks in RUN.
        cyc(2);
        rst = 1'b1;
        chk("rst_sec", 32'(sec), 32'd0);
        chk("rst_min", 32'(min), 32'd0);
        chk("rst_hour", 32'(hour), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_dc", 32'(day_carry), 32'd0);
        tick = 1'b1; cyc(60); tick = 1'b0;
        chk("t60_sec", 32'(sec), 32'd0);
        chk("t60_min", 32'(min), 32'd1);
        chk("t60_dc", 32'(day_carry), 32'd0);

        // Preload 23:59:58, back to RUN, two ticks cross midnight.
        press_mode(); press_inc(23);
        press_mode(); press_inc(58);
        press_mode(); press_inc(58);
        chk("pre_hour", 32'(hour), 32'd23);
        chk("pre_min", 32'(min), 32'd59);
        chk("pre_sec", 32'(sec), 32'd58);
        press_mode();
        chk("pre_mode", 32'(mode), 32'd0);
        tick = 1'b1; cyc(2); tick = 1'b0;
        chk("mid_dc", 32'(day_carry), 32'd1);
        chk("mid_hour", 32'(hour), 32'd0);
        chk("mid_min", 32'(min), 32'd0);
        chk("mid_sec", 32'(sec), 32'd0);
        cyc(1);
        chk("mid_dc_off", 32'(day_carry), 32'd0);

        // Hour set wraps at 24; ticks ignored meanwhile.
        press_mode();
        tick = 1'b1; press_inc(25); tick = 1'b0;
        chk("sh_mode", 32'(mode), 32'd1);
        chk("sh_hour", 32'(hour), 32'd1);
        chk("sh_min", 32'(min), 32'd0);
        chk("sh_sec", 32'(sec), 32'd0);

        // SET_SEC -> RUN with a coincident tick: tick_clr, tick dropped.
        press_mode(); press_mode();
        press_inc(5);
        chk("ss_mode", 32'(mode), 32'd3);
        btn_mode = 1'b1; tick = 1'b1; cyc(1);
        chk("ex_mode", 32'(mode), 32'd0);
        chk("ex_tclr", 32'(tick_clr), 32'd1);
        chk("ex_sec", 32'(sec), 32'd5);
        btn_mode = 1'b0; tick = 1'b0; cyc(1);
        chk("ex_tclr_off", 32'(tick_clr), 32'd0);
        chk("ex_sec2", 32'(sec), 32'd5);

        // Mode and inc edges together in SET_MIN: mode wins.
        press_mode(); press_mode(); press_inc(3);
        btn_mode = 1'b1; btn_inc = 1'b1; cyc(1);
        chk("both_mode", 32'(mode), 32'd3);
        chk("both_min", 32'(min), 32'd3);
        btn_mode = 1'b0; btn_inc = 1'b0; cyc(1);
        press_mode();

        // btn_mode held through reset gives no edge until re-pressed.
        btn_mode = 1'b1; rst = 1'b0; cyc(2);
        rst = 1'b1; cyc(3);
        chk("hold_mode", 32'(mode), 32'd0);
        btn_mode = 1'b0; cyc(1);
        btn_mode = 1'b1; cyc(1);
        chk("repress_mode", 32'(mode), 32'd1);
        btn_mode = 1'b0; cyc(1);

        // Reset in SET_MIN with min=37.
        press_mode(); press_inc(37);
        chk("sm_min", 32'(min), 32'd37);
        rst = 1'b0; cyc(1);
        chk("mrst_mode", 32'(mode), 32'd0);
        chk("mrst_min", 32'(min), 32'd0);
        chk("mrst_hour", 32'(hour), 32'd0);
        chk("mrst_sec", 32'(sec), 32'd0);
        chk("mrst_tclr", 32'(tick_clr), 32'd0);
        chk("mrst_dc", 32'(day_carry), 32'd0);
        rst = 1'b1; cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Controller for the seconds/minutes/hours time-of-day chain. It consumes the 1 Hz `tick` pulse from the `tick` prescaler and owns the sec/min/hour counters. It also runs a user set-mode FSM driven by two debounced push-buttons. It emits a single-cycle `day_carry` to the date chain (day/month/year/century) and a `tick_clr` pulse that restarts the prescaler when the user leaves set mode.

## Interface
Parameters:
- `SEC_MOD`, 60, seconds modulus
- `MIN_MOD`, 60, minutes modulus
- `HOUR_MOD`, 24, hours modulus

Ports:
- `clk`  in  1  system clock (50 MHz)
- `rst`  in  1  synchronous, active-low reset
- `tick`  in  1  1 Hz single-cycle pulse from prescaler
- `btn_mode`  in  1  debounced mode button, level, active-high
- `btn_inc`  in  1  debounced increment button, level, active-high
- `sec`  out  6  seconds, binary, 0..SEC_MOD-1
- `min`  out  6  minutes, binary, 0..MIN_MOD-1
- `hour`  out  5  hours, binary, 0..HOUR_MOD-1
- `mode`  out  2  current FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
- `day_carry`  out  1  single-cycle pulse on hour wrap in RUN
- `tick_clr`  out  1  single-cycle pulse: prescaler count restart

## Operation
- FSM states: RUN → SET_HOUR → SET_MIN → SET_SEC → RUN.
  - Each rising edge of `btn_mode` advances one state.
  - No other transitions.
- Edge detect: `btn_x_q` holds `btn_x` from the previous cycle.
  - An edge is `btn_x & ~btn_x_q`.
  - `btn_x_q` resets to 1, so a button held through reset produces no edge until it is released and pressed again.
- RUN:
  - Each `tick` increments `sec`.
  - A `sec` wrap (SEC_MOD-1→0) increments `min` in the same cycle.
  - A `min` wrap increments `hour`.
  - An `hour` wrap (HOUR_MOD-1→0) asserts `day_carry`.
  - The `btn_inc` edge is ignored.
- SET_x:
  - `tick` is ignored; time is frozen.
  - A `btn_inc` edge increments only the selected field, wrapping to 0 with no carry into the next field and no `day_carry`.
  - SET_SEC increment wraps sec only.
- Leaving SET_SEC for RUN asserts `tick_clr` so the first second after setting is a full second.
- Simultaneous events:
  - `btn_mode` and `btn_inc` edges in the same cycle in a SET state: the mode transition happens and the increment is discarded.
  - `tick` and `btn_mode` edge in the same cycle in RUN: the tick increment is applied and the state moves to SET_HOUR.
  - `tick` in the same cycle as the SET_SEC→RUN transition: the tick is discarded.
- Reset (`rst`=0 at any clock edge, including mid-set):
  - mode=RUN, sec=min=hour=0
  - day_carry=0, tick_clr=0, btn_mode_q=btn_inc_q=1

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A `tick` sampled high at edge N gives an updated `sec`/`min`/`hour` after edge N (visible in cycle N+1).
- `day_carry` is high for exactly cycle N+1 when 23:59:59→00:00:00, coincident with the zeroed fields.
- A button edge detected at edge N gives `mode`/field update visible in cycle N+1. `tick_clr` is high for exactly that cycle on SET_SEC→RUN.
- Per-press latency from `btn_x` rising to effect: 1 cycle.
- Minimum spacing between accepted presses: 2 cycles (release and press).
- Width rules:
  - Fields compare against MOD-1 for wrap.
  - Increments use field width only; no overflow beyond MOD-1 is possible.
  - Parameters must satisfy SEC_MOD, MIN_MOD ≤ 64 and HOUR_MOD ≤ 32.

## Structure
- Shared package `clock_pkg`:
  - mode encodings (MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN, MODE_SET_SEC)
  - default moduli
  - field widths (SEC_W=6, MIN_W=6, HOUR_W=5)
- Sub-module `mod_counter`:
  - parameters MOD and W
  - ports clk, rst, inc, q, wrap
  - wrap is combinational from the current `q==MOD-1 & inc`
  - instantiated three times
- This block supplies each instance's `inc` from the FSM: tick/carry in RUN, button edge in SET.
- The FSM, edge detectors, `day_carry` and `tick_clr` registers live in `time_set_ctrl`.

## Test plan
- Reset, then 60 ticks in RUN → sec returns to 0 and min=1 in the cycle after the 60th tick; day_carry stays 0.
- Preload 23:59:58 via set mode, return to RUN, give 2 ticks → after the 2nd tick 00:00:00 and day_carry=1 for exactly one cycle.
- Press mode once, then inc 25 times → mode=1 and hour=1 (wraps at 24); min and sec unchanged; ticks applied meanwhile have no effect.
- Press mode 3 times from SET_HOUR → mode returns to 0; tick_clr=1 for one cycle on the SET_SEC→RUN edge; a tick in that same cycle leaves sec unchanged.
- Mode and inc rising in the same cycle in SET_MIN → mode=3 and min unchanged. Hold btn_mode high through reset release → mode stays 0 until release and re-press.
- Assert rst=0 mid SET_MIN with min=37 → next cycle mode=0, all fields 0, no tick_clr or day_carry pulse.
